// File: rtl/spi_target_pkg.sv
// Shared types and helpers for the SPI target endpoint.
package spi_target_pkg;

  localparam int SPI_MAX_FRAME_W = 16;

  typedef enum logic [1:0] {
    SPT_IDLE  = 2'd0,
    SPT_LOAD  = 2'd1,
    SPT_SHIFT = 2'd2
  } type_spi_target_states_e;

  // Keeps the low size+1 bits of a frame word.
  function automatic logic [SPI_MAX_FRAME_W-1:0] frame_mask(input logic [3:0] size);
    frame_mask = {SPI_MAX_FRAME_W{1'b1}} >> (4'd15 - size);
  endfunction

endpackage

// File: rtl/spi_target_if.sv
// SPI pins, frame configuration and TX/RX peripheral-side handshake of the SPI target.
interface spi_target_if;
  logic        spi_clk_i;
  logic        spi_cs_i;
  logic        spi_mosi_i;
  logic        spi_miso_o;
  logic        spi_miso_oe_o;
  logic        spi_clk_polarity;
  logic        spi_clk_phase;
  logic [3:0]  spi_data_size;
  logic [15:0] tx_data_i;
  logic        tx_valid_i;
  logic        tx_ready_o;
  logic [15:0] rx_data_o;
  logic        rx_valid_o;
  logic        tx_underrun_o;
  logic        spi_busy_o;

  modport slave (
    input  spi_clk_i, spi_cs_i, spi_mosi_i, spi_clk_polarity, spi_clk_phase,
           spi_data_size, tx_data_i, tx_valid_i,
    output spi_miso_o, spi_miso_oe_o, tx_ready_o, rx_data_o, rx_valid_o,
           tx_underrun_o, spi_busy_o
  );

  modport master (
    output spi_clk_i, spi_cs_i, spi_mosi_i, spi_clk_polarity, spi_clk_phase,
           spi_data_size, tx_data_i, tx_valid_i,
    input  spi_miso_o, spi_miso_oe_o, tx_ready_o, rx_data_o, rx_valid_o,
           tx_underrun_o, spi_busy_o
  );
endinterface

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one external SPI pin, with a selectable reset level.
module spi_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  // Shift the raw pin through the synchronizer chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {SYNC_STAGES{rst_val}};
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/spi_target.sv
// SPI target: oversamples SCLK/CS/MOSI, shifts 1..16-bit frames in all four modes, drives MISO.
module spi_target #(
  parameter int SYNC_STAGES = 2
) (
  input logic         clk,
  input logic         rst,
  spi_target_if.slave bus
);
  import spi_target_pkg::*;

  logic sclk_sync, cs_sync, mosi_sync;
  logic sclk_hist, cs_hist;
  logic cs_fall, cs_rise, sclk_rise, sclk_fall;
  logic lead_edge, trail_edge, active, sample_edge, shift_edge, last_bit, load;
  type_spi_target_states_e state, state_next;
  logic        cpol, cpha;
  logic [3:0]  size;
  logic [15:0] hold, load_word, tx_shift, rx_shift, rx_data;
  logic        hold_valid;
  logic [3:0]  bit_cnt;
  logic        frame_done, reload_pend, underrun_pend;
  logic        miso, oe, rx_valid, underrun, busy;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst(rst), .rst_val(1'b0), .d(bus.spi_clk_i), .q(sclk_sync)
  );
  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst(rst), .rst_val(1'b1), .d(bus.spi_cs_i), .q(cs_sync)
  );
  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst(rst), .rst_val(1'b0), .d(bus.spi_mosi_i), .q(mosi_sync)
  );

  assign cs_fall     = cs_hist & ~cs_sync;
  assign cs_rise     = ~cs_hist & cs_sync;
  assign sclk_rise   = sclk_sync & ~sclk_hist;
  assign sclk_fall   = ~sclk_sync & sclk_hist;
  assign lead_edge   = cpol ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol ? sclk_rise : sclk_fall;
  assign active      = (state == SPT_SHIFT) & ~cs_rise;
  assign sample_edge = active & (cpha ? trail_edge : lead_edge);
  assign shift_edge  = active & (cpha ? lead_edge : trail_edge);
  assign last_bit    = (bit_cnt == size);
  assign load_word   = hold_valid ? hold : 16'd0;

  // Edge history, synchronized busy flag and per-frame configuration latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_hist <= 1'b0;
      cs_hist   <= 1'b1;
      busy      <= 1'b0;
      cpol      <= 1'b0;
      cpha      <= 1'b0;
      size      <= 4'd0;
    end else begin
      sclk_hist <= sclk_sync;
      cs_hist   <= cs_sync;
      busy      <= ~cs_sync;
      if ((state == SPT_IDLE) && cs_fall) begin
        cpol <= bus.spi_clk_polarity;
        cpha <= bus.spi_clk_phase;
        size <= bus.spi_data_size;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SPT_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and shift-register load request; CPHA=1 reloads at frame completion,
  // CPHA=0 on the trailing edge after it, so the MSB is ready before the next leading edge.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      SPT_IDLE: begin
        if (cs_fall) state_next = SPT_LOAD;
        else         state_next = SPT_IDLE;
      end
      SPT_LOAD: begin
        if (cs_rise) begin
          state_next = SPT_IDLE;
        end else begin
          state_next = SPT_SHIFT;
          load       = 1'b1;
        end
      end
      SPT_SHIFT: begin
        if (cs_rise) state_next = SPT_IDLE;
        else         state_next = SPT_SHIFT;
        if (cpha) load = sample_edge & last_bit;
        else      load = shift_edge & reload_pend;
      end
      default: begin
        state_next = SPT_IDLE;
        load       = 1'b0;
      end
    endcase
  end

  // Holding register: a load consumes it, a same-cycle accept refills it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold       <= 16'd0;
      hold_valid <= 1'b0;
    end else begin
      if (load) hold_valid <= 1'b0;
      if (bus.tx_valid_i && !hold_valid) begin
        hold       <= bus.tx_data_i;
        hold_valid <= 1'b1;
      end
    end
  end

  // MISO shifter; a reload without data only flags underrun once the next frame starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_shift      <= 16'd0;
      miso          <= 1'b0;
      oe            <= 1'b0;
      underrun      <= 1'b0;
      underrun_pend <= 1'b0;
      reload_pend   <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (state_next == SPT_IDLE) begin
        tx_shift      <= 16'd0;
        miso          <= 1'b0;
        oe            <= 1'b0;
        underrun_pend <= 1'b0;
        reload_pend   <= 1'b0;
      end else if (state == SPT_IDLE) begin
        oe <= 1'b1;
      end else if (load) begin
        if (state == SPT_LOAD) underrun <= ~hold_valid;
        else                   underrun_pend <= ~hold_valid;
        reload_pend <= 1'b0;
        if (cpha) begin
          tx_shift <= load_word;
        end else begin
          miso     <= load_word[size];
          tx_shift <= load_word << 1;
        end
      end else begin
        if (shift_edge) begin
          miso     <= tx_shift[size];
          tx_shift <= tx_shift << 1;
        end
        if (sample_edge && last_bit && !cpha) reload_pend <= 1'b1;
        if (active && lead_edge && underrun_pend) begin
          underrun      <= 1'b1;
          underrun_pend <= 1'b0;
        end
      end
    end
  end

  // MOSI sampler, bit counter and received-frame strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_shift   <= 16'd0;
      bit_cnt    <= 4'd0;
      frame_done <= 1'b0;
      rx_data    <= 16'd0;
      rx_valid   <= 1'b0;
    end else begin
      rx_valid   <= frame_done;
      frame_done <= 1'b0;
      if (frame_done) rx_data <= rx_shift & frame_mask(size);
      if (state_next == SPT_IDLE) begin
        bit_cnt <= 4'd0;
      end else if (sample_edge) begin
        rx_shift <= {rx_shift[14:0], mosi_sync};
        if (last_bit) begin
          bit_cnt    <= 4'd0;
          frame_done <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end
    end
  end

  assign bus.spi_miso_o    = miso;
  assign bus.spi_miso_oe_o = oe;
  assign bus.tx_ready_o    = ~hold_valid;
  assign bus.rx_data_o     = rx_data;
  assign bus.rx_valid_o    = rx_valid;
  assign bus.tx_underrun_o = underrun;
  assign bus.spi_busy_o    = busy;

endmodule

// File: tb/tb_spi_target.sv
// Scoreboard bench for spi_target: acts as SPI controller, predicts RX words, MISO words and underruns.
module tb_spi_target;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_target_if bus();

  spi_target #(.SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int under_cnt = 0;
  logic [15:0] exp_rx_q[$];
  logic [15:0] last_rx = 16'd0;
  logic [15:0] mon_exp;

  logic [15:0] mosi_w[4];
  logic [15:0] tx_w[4];
  bit          tx_has[4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every rx strobe is matched against the oldest predicted frame.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.tx_underrun_o) under_cnt++;
      if (bus.rx_valid_o) begin
        if (exp_rx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got 0x%0h, expected no strobe at %0t", bus.rx_data_o, $time);
        end else begin
          mon_exp = exp_rx_q.pop_front();
          check("rx_data", {16'd0, bus.rx_data_o}, {16'd0, mon_exp});
          last_rx = mon_exp;
        end
      end
    end
  end

  task automatic tx_write(input logic [15:0] w);
    int n;
    n = 0;
    while (!bus.tx_ready_o && n < 20) begin
      wait_clk(1);
      n++;
    end
    if (n == 20) begin
      checks++;
      errors++;
      $display("FAIL tx_ready_timeout: got 0, expected 1 within 20 clk");
    end
    bus.tx_data_i  = w;
    bus.tx_valid_i = 1'b1;
    wait_clk(1);
    bus.tx_valid_i = 1'b0;
  endtask

  // One CS-low session of nfr frames; abort_bits >= 0 raises CS after that many bits.
  task automatic session(input bit cpol, input bit cpha, input int sz, input int nfr,
                         input int half, input int abort_bits);
    int u0, exp_under;
    logic [15:0] mask, got, exp_miso;
    mask = 16'((32'd1 << (sz + 1)) - 32'd1);
    bus.spi_clk_polarity = cpol;
    bus.spi_clk_phase    = cpha;
    bus.spi_data_size    = 4'(sz);
    bus.spi_clk_i        = cpol;
    bus.spi_mosi_i       = 1'b0;
    wait_clk(4);
    if (tx_has[0]) tx_write(tx_w[0]);
    wait_clk(2);
    u0 = under_cnt;
    exp_under = 0;
    bus.spi_cs_i = 1'b0;
    if (!cpha) bus.spi_mosi_i = mosi_w[0][sz];
    wait_clk(half + 5);
    check("oe_selected", {31'd0, bus.spi_miso_oe_o}, 32'd1);
    check("busy_selected", {31'd0, bus.spi_busy_o}, 32'd1);
    check("tx_ready_after_load", {31'd0, bus.tx_ready_o}, 32'd1);
    for (int f = 0; f < nfr; f++) begin
      if (!tx_has[f]) exp_under++;
      if (abort_bits < 0) exp_rx_q.push_back(mosi_w[f] & mask);
      if (f + 1 < nfr && tx_has[f + 1]) tx_write(tx_w[f + 1]);
      got = 16'd0;
      for (int b = sz; b >= 0; b--) begin
        if (abort_bits >= 0 && (sz - b) == abort_bits) break;
        if (!cpha) begin
          got = {got[14:0], bus.spi_miso_o};
          bus.spi_clk_i = ~cpol;
          wait_clk(half);
          bus.spi_clk_i = cpol;
          if (b > 0) bus.spi_mosi_i = mosi_w[f][b - 1];
          else if (f + 1 < nfr) bus.spi_mosi_i = mosi_w[f + 1][sz];
          wait_clk(half);
        end else begin
          bus.spi_mosi_i = mosi_w[f][b];
          bus.spi_clk_i = ~cpol;
          wait_clk(half);
          got = {got[14:0], bus.spi_miso_o};
          bus.spi_clk_i = cpol;
          wait_clk(half);
        end
      end
      if (abort_bits < 0) begin
        exp_miso = tx_has[f] ? (tx_w[f] & mask) : 16'd0;
        check("miso_frame", {16'd0, got}, {16'd0, exp_miso});
      end
    end
    bus.spi_cs_i = 1'b1;
    wait_clk(4);
    check("oe_released", {31'd0, bus.spi_miso_oe_o}, 32'd0);
    if (abort_bits >= 0) check("rx_data_kept", {16'd0, bus.rx_data_o}, {16'd0, last_rx});
    wait_clk(4);
    check("underrun_count", under_cnt - u0, exp_under);
    check("rx_frames_pending", exp_rx_q.size(), 32'd0);
    check("busy_idle", {31'd0, bus.spi_busy_o}, 32'd0);
    exp_rx_q.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bus.spi_clk_i = 1'b0;
    bus.spi_cs_i = 1'b1;
    bus.spi_mosi_i = 1'b0;
    bus.spi_clk_polarity = 1'b0;
    bus.spi_clk_phase = 1'b0;
    bus.spi_data_size = 4'd0;
    bus.tx_data_i = 16'd0;
    bus.tx_valid_i = 1'b0;
    rst = 1'b1;
    wait_clk(3);
    check("rst_miso", {31'd0, bus.spi_miso_o}, 32'd0);
    check("rst_oe", {31'd0, bus.spi_miso_oe_o}, 32'd0);
    check("rst_tx_ready", {31'd0, bus.tx_ready_o}, 32'd1);
    check("rst_rx_data", {16'd0, bus.rx_data_o}, 32'd0);
    check("rst_rx_valid", {31'd0, bus.rx_valid_o}, 32'd0);
    check("rst_underrun", {31'd0, bus.tx_underrun_o}, 32'd0);
    check("rst_busy", {31'd0, bus.spi_busy_o}, 32'd0);
    rst = 1'b0;
    wait_clk(4);

    // Mode 0, 8 bits, 0x3C out, 0xA5 in
    mosi_w[0] = 16'h00A5; tx_w[0] = 16'h003C; tx_has[0] = 1'b1;
    session(1'b0, 1'b0, 7, 1, 4, -1);
    // Mode 3, 16 bits
    mosi_w[0] = 16'h1234; tx_w[0] = 16'hBEEF; tx_has[0] = 1'b1;
    session(1'b1, 1'b1, 15, 1, 5, -1);
    // Mode 1, 4 bits, underrun
    mosi_w[0] = 16'($urandom_range(0, 15)); tx_has[0] = 1'b0;
    session(1'b0, 1'b1, 3, 1, 4, -1);
    // Two back-to-back frames in mode 0
    mosi_w[0] = 16'h0011; mosi_w[1] = 16'h0022;
    tx_w[0] = 16'h00AA; tx_w[1] = 16'h0055; tx_has[0] = 1'b1; tx_has[1] = 1'b1;
    session(1'b0, 1'b0, 7, 2, 4, -1);
    // Aborted frame, then a full one
    mosi_w[0] = 16'h00C3; tx_w[0] = 16'h0081; tx_has[0] = 1'b1;
    session(1'b0, 1'b0, 7, 1, 4, 3);
    mosi_w[0] = 16'h0096; tx_w[0] = 16'h0069; tx_has[0] = 1'b1;
    session(1'b0, 1'b0, 7, 1, 4, -1);

    // Reset in the middle of a frame
    bus.spi_clk_polarity = 1'b0; bus.spi_clk_phase = 1'b0; bus.spi_data_size = 4'd7;
    bus.spi_cs_i = 1'b0; bus.spi_mosi_i = 1'b1;
    wait_clk(8);
    repeat (3) begin
      bus.spi_clk_i = 1'b1; wait_clk(4);
      bus.spi_clk_i = 1'b0; wait_clk(4);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_miso", {31'd0, bus.spi_miso_o}, 32'd0);
    check("mid_rst_oe", {31'd0, bus.spi_miso_oe_o}, 32'd0);
    check("mid_rst_tx_ready", {31'd0, bus.tx_ready_o}, 32'd1);
    check("mid_rst_rx_data", {16'd0, bus.rx_data_o}, 32'd0);
    check("mid_rst_busy", {31'd0, bus.spi_busy_o}, 32'd0);
    wait_clk(2);
    rst = 1'b0;
    bus.spi_cs_i = 1'b1;
    last_rx = 16'd0;
    wait_clk(4);
    mosi_w[0] = 16'h005A; tx_w[0] = 16'h00E7; tx_has[0] = 1'b1;
    session(1'b0, 1'b0, 7, 1, 4, -1);

    // Randomized sessions across all modes and sizes
    for (int s = 0; s < 20; s++) begin
      for (int f = 0; f < 4; f++) begin
        mosi_w[f] = 16'($urandom);
        tx_w[f]   = 16'($urandom);
        tx_has[f] = ($urandom_range(0, 3) != 0);
      end
      session(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 15),
              $urandom_range(1, 3), $urandom_range(4, 7), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
